// File: rtl/mem_access_sequencer.sv
// ============================================================================
// mem_access_sequencer
// ----------------------------------------------------------------------------
// Multicycle control sequencer for the CPU memory path. Each instruction is
// stepped through FETCH -> DECODE -> EXEC -> (MEM) -> (WRITEBACK), or into
// HALT. The 3-bit state bus is decoded by the data register, instruction
// register and PC logic.
//
// The block owns the memory bus handshake (read/write strobes, byteenable,
// waitrequest stalls) and halts the core on misaligned loads and stores,
// raising a sticky fault flag.
//
// Parameters:
//   RESET_STATE  state encoding entered on reset (FETCH = 0)
//   ADDR_LO_W    width of the low address bits used for alignment/lanes
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous, active-high reset
//   instr_is_load    in   decoded load, sampled in EXEC
//   instr_is_store   in   decoded store, sampled in EXEC
//   instr_is_halt    in   decoded halt, sampled in EXEC
//   instr_writes_rf  in   instruction writes a GPR, sampled in EXEC
//   mem_size         in   0 byte, 1 half, 2/3 word
//   mem_addr_lo      in   effective address low bits
//   waitrequest      in   memory stall (only honoured in FETCH and MEM)
//   state            out  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WRITEBACK, 5 HALT
//   read             out  memory read strobe
//   write            out  memory write strobe
//   byteenable       out  active byte lanes
//   ir_load          out  instruction register capture pulse
//   pc_write         out  PC update pulse
//   rf_write         out  register file write enable
//   active           out  high until one cycle after HALT is entered
//   fault            out  sticky misalignment flag
//   stall_cycles     out  (MEM_STALL_COUNT_EN only) count of stalled
//                         read/write cycles, saturating, frozen in HALT
//
// Optional feature macro: MEM_STALL_COUNT_EN
// ============================================================================
module mem_access_sequencer #(
    parameter int RESET_STATE = 0,
    parameter int ADDR_LO_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_is_load,
    input  logic                 instr_is_store,
    input  logic                 instr_is_halt,
    input  logic                 instr_writes_rf,
    input  logic [1:0]           mem_size,
    input  logic [ADDR_LO_W-1:0] mem_addr_lo,
    input  logic                 waitrequest,
    output logic [2:0]           state,
    output logic                 read,
    output logic                 write,
    output logic [3:0]           byteenable,
    output logic                 ir_load,
    output logic                 pc_write,
    output logic                 rf_write,
    output logic                 active,
`ifdef MEM_STALL_COUNT_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 fault
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXEC      = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam state_t RST_STATE = state_t'(RESET_STATE[2:0]);

    state_t     state_q;
    logic       load_q;
    logic       writes_rf_q;
    logic [3:0] be_q;
    logic       fault_q;
    logic       active_q;

    logic [3:0] be_calc;
    logic       misaligned;
    logic       is_mem_op;

    // Lane selection and alignment check for the access presented in EXEC.
    // Size 3 is handled as a word access.
    always_comb begin
        be_calc    = 4'b0000;
        misaligned = 1'b0;
        case (mem_size)
            2'd0: begin
                be_calc    = 4'b0001 << mem_addr_lo;
                misaligned = 1'b0;
            end
            2'd1: begin
                be_calc    = mem_addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = mem_addr_lo[0];
            end
            default: begin
                be_calc    = 4'b1111;
                misaligned = (mem_addr_lo != '0);
            end
        endcase
    end

    assign is_mem_op = instr_is_load | instr_is_store;

    // Main sequencer. The decode inputs and the lane mask are latched in EXEC
    // so that MEM and WRITEBACK do not depend on the decoder staying stable.
    // A simultaneous load and store is treated as a load, which is why only
    // the load flag is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RST_STATE;
            load_q      <= 1'b0;
            writes_rf_q <= 1'b0;
            be_q        <= 4'b0000;
            fault_q     <= 1'b0;
            active_q    <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!waitrequest) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    load_q      <= instr_is_load;
                    writes_rf_q <= instr_writes_rf;
                    be_q        <= be_calc;
                    if (instr_is_halt) begin
                        state_q <= S_HALT;
                    end else if (is_mem_op && misaligned) begin
                        state_q <= S_HALT;
                        fault_q <= 1'b1;
                    end else if (is_mem_op) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (!waitrequest) begin
                        state_q <= load_q ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    state_q <= S_FETCH;
                end
                S_HALT: begin
                    active_q <= 1'b0;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes and pulses are decoded from the current state. Reset gates them
    // combinationally so an in-flight transfer is dropped in the same cycle
    // reset is seen, not one cycle later.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'b0000;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        rf_write   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    read       = 1'b1;
                    byteenable = 4'b1111;
                    ir_load    = !waitrequest;
                end
                S_MEM: begin
                    byteenable = be_q;
                    if (load_q) begin
                        read = 1'b1;
                    end else begin
                        write    = 1'b1;
                        pc_write = !waitrequest;
                    end
                end
                S_WRITEBACK: begin
                    rf_write = writes_rf_q | load_q;
                    pc_write = 1'b1;
                end
                default: begin
                    read = 1'b0;
                end
            endcase
        end
    end

    assign state  = state_q;
    assign active = active_q;
    assign fault  = fault_q;

`ifdef MEM_STALL_COUNT_EN
    logic [31:0] stall_q;

    // Counts bus cycles lost to waitrequest. Read/write are already zero in
    // HALT, but the explicit HALT check keeps the count frozen regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 32'd0;
        end else if ((read | write) && waitrequest && (state_q != S_HALT)
                     && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// tb_mem_access_sequencer
// ----------------------------------------------------------------------------
// Directed bench for mem_access_sequencer. Each step drives inputs just after
// a rising edge, pushes the expected outputs for that cycle to a scoreboard,
// and pops/compares them on the following falling edge.
// Define MEM_STALL_COUNT_EN to also check the stall counter.
// ============================================================================
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_is_load;
    logic        instr_is_store;
    logic        instr_is_halt;
    logic        instr_writes_rf;
    logic [1:0]  mem_size;
    logic [1:0]  mem_addr_lo;
    logic        waitrequest;
    logic [2:0]  state;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic        ir_load;
    logic        pc_write;
    logic        rf_write;
    logic        active;
    logic        fault;
`ifdef MEM_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    mem_access_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .instr_is_load   (instr_is_load),
        .instr_is_store  (instr_is_store),
        .instr_is_halt   (instr_is_halt),
        .instr_writes_rf (instr_writes_rf),
        .mem_size        (mem_size),
        .mem_addr_lo     (mem_addr_lo),
        .waitrequest     (waitrequest),
        .state           (state),
        .read            (read),
        .write           (write),
        .byteenable      (byteenable),
        .ir_load         (ir_load),
        .pc_write        (pc_write),
        .rf_write        (rf_write),
        .active          (active),
`ifdef MEM_STALL_COUNT_EN
        .stall_cycles    (stall_cycles),
`endif
        .fault           (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       rd;
        logic       wr;
        logic [3:0] be;
        logic       irl;
        logic       pcw;
        logic       rfw;
        logic       act;
        logic       flt;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    compared   = 0;
    int    mismatched = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic rd, input logic wr,
                                input logic [3:0] be, input logic irl, input logic pcw,
                                input logic rfw, input logic act, input logic flt);
        exp_t e;
        e.st = st; e.rd = rd; e.wr = wr; e.be = be; e.irl = irl;
        e.pcw = pcw; e.rfw = rfw; e.act = act; e.flt = flt;
        return e;
    endfunction

    task automatic compareField(input string tag, input string field,
                                input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic setInstr(input logic ld, input logic stv, input logic hl,
                            input logic wrf, input logic [1:0] sz, input logic [1:0] addr);
        instr_is_load   = ld;
        instr_is_store  = stv;
        instr_is_halt   = hl;
        instr_writes_rf = wrf;
        mem_size        = sz;
        mem_addr_lo     = addr;
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic wt, input exp_t e);
        reset       = rst;
        waitrequest = wt;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        @(negedge clk);
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries required=1");
        end else begin
            e   = expQ.pop_front();
            tag = tagQ.pop_front();
            compareField(tag, "state",      {29'd0, state},      {29'd0, e.st});
            compareField(tag, "read",       {31'd0, read},       {31'd0, e.rd});
            compareField(tag, "write",      {31'd0, write},      {31'd0, e.wr});
            compareField(tag, "byteenable", {28'd0, byteenable}, {28'd0, e.be});
            compareField(tag, "ir_load",    {31'd0, ir_load},    {31'd0, e.irl});
            compareField(tag, "pc_write",   {31'd0, pc_write},   {31'd0, e.pcw});
            compareField(tag, "rf_write",   {31'd0, rf_write},   {31'd0, e.rfw});
            compareField(tag, "active",     {31'd0, active},     {31'd0, e.act});
            compareField(tag, "fault",      {31'd0, fault},      {31'd0, e.flt});
            compareField(tag, "rd_wr_excl", {31'd0, read & write}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic rst, input logic wt, input exp_t e);
        applyStimulus(tag, rst, wt, e);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        waitrequest = 1'b0;
        setInstr(0, 0, 0, 1, 2'd0, 2'd0);
        @(posedge clk);
        #1;

        // Reset held for two cycles
        step("rst0", 1, 0, mk(3'd0, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("rst1", 1, 0, mk(3'd0, 0, 0, 4'h0, 0, 0, 0, 1, 0));

        // ALU instruction writing a register: 0,1,2,4
        setInstr(0, 0, 0, 1, 2'd2, 2'd0);
        step("alu_fetch",  0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
        step("alu_decode", 0, 0, mk(3'd1, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("alu_exec",   0, 0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("alu_wb",     0, 0, mk(3'd4, 0, 0, 4'h0, 0, 1, 1, 1, 0));

        // Load word, three MEM stalls; writes_rf low but load forces rf_write
        setInstr(1, 0, 0, 0, 2'd2, 2'd0);
        step("lw_fetch",  0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
        step("lw_decode", 0, 0, mk(3'd1, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("lw_exec",   0, 0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("lw_mem_w1", 0, 1, mk(3'd3, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("lw_mem_w2", 0, 1, mk(3'd3, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("lw_mem_w3", 0, 1, mk(3'd3, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("lw_mem_ok", 0, 0, mk(3'd3, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("lw_wb",     0, 0, mk(3'd4, 0, 0, 4'h0, 0, 1, 1, 1, 0));

        // Store byte to addr 10, after two FETCH stalls
        setInstr(0, 1, 0, 0, 2'd0, 2'b10);
        step("sb_fetch_w1", 0, 1, mk(3'd0, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("sb_fetch_w2", 0, 1, mk(3'd0, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("sb_fetch",    0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
        step("sb_decode",   0, 0, mk(3'd1, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("sb_exec",     0, 0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("sb_mem",      0, 0, mk(3'd3, 0, 1, 4'b0100, 0, 1, 0, 1, 0));

        // Misaligned half load at addr 01: straight to HALT with fault
        setInstr(1, 0, 0, 1, 2'd1, 2'b01);
        step("lh_fetch",  0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
        step("lh_decode", 0, 0, mk(3'd1, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("lh_exec",   0, 0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("lh_halt0",  0, 1, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 1, 1));
        step("lh_halt1",  0, 1, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 0, 1));
        step("lh_halt2",  0, 0, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 0, 1));
`ifdef MEM_STALL_COUNT_EN
        compareField("stall_in_halt", "stall_cycles", stall_cycles, 32'd5);
`endif
        step("lh_rst",    1, 0, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 0, 1));

        // Halt and load together: halt wins, no MEM, no fault
        setInstr(1, 0, 1, 1, 2'd2, 2'd0);
        step("hl_fetch",  0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
        step("hl_decode", 0, 0, mk(3'd1, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("hl_exec",   0, 0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("hl_halt0",  0, 0, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("hl_halt1",  0, 0, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        step("hl_rst",    1, 0, mk(3'd5, 0, 0, 4'h0, 0, 0, 0, 0, 0));

        // Reset in the middle of a stalled MEM read
        setInstr(1, 0, 0, 1, 2'd2, 2'd0);
        step("rm_fetch",  0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
        step("rm_decode", 0, 0, mk(3'd1, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("rm_exec",   0, 0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("rm_mem_w",  0, 1, mk(3'd3, 1, 0, 4'hF, 0, 0, 0, 1, 0));
        step("rm_rst",    1, 1, mk(3'd3, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        step("rm_after",  0, 0, mk(3'd0, 1, 0, 4'hF, 1, 0, 0, 1, 0));
`ifdef MEM_STALL_COUNT_EN
        compareField("stall_after_rst", "stall_cycles", stall_cycles, 32'd0);
`endif

        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain observed=%0d entries required=0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multicycle control sequencer for the CPU memory path.
- Steps each instruction through FETCH, DECODE, EXEC, MEM, WRITEBACK and HALT. Drives the 3-bit state bus that the data register, instruction register and PC logic decode.
- Owns the memory bus handshake: read/write strobes, byteenable and waitrequest stalls.
- Detects misaligned accesses and halts the core on them.

Parameters:
- RESET_STATE, 0, state entered on reset (FETCH encoding).
- ADDR_LO_W, 2, width of the low address bits used for alignment and lane selection.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- instr_is_load  input  1  decoded load (lw/lh/lhu/lb/lbu); sampled in EXEC
- instr_is_store  input  1  decoded store (sw/sh/sb); sampled in EXEC
- instr_is_halt  input  1  decoded halt (jr to address 0); sampled in EXEC
- instr_writes_rf  input  1  instruction writes a GPR; sampled in EXEC
- mem_size  input  2  access size: 0 byte, 1 half, 2 word (3 treated as word)
- mem_addr_lo  input  2  effective address [1:0]
- waitrequest  input  1  memory stall
- state  output  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WRITEBACK, 5 HALT
- read  output  1  memory read strobe
- write  output  1  memory write strobe
- byteenable  output  4  active byte lanes
- ir_load  output  1  instruction register capture pulse
- pc_write  output  1  PC update pulse
- rf_write  output  1  register file write enable
- active  output  1  high until HALT
- fault  output  1  sticky misalignment flag

Behaviour:
- Reset: state=0, read/write/ir_load/pc_write/rf_write/fault=0, byteenable=0, active=1.
  - Reset mid-transfer drops all strobes the same cycle.
  - FETCH read is asserted from the first cycle after reset deasserts.
- FETCH: read=1, byteenable=1111.
  - waitrequest=1: hold state.
  - waitrequest=0: ir_load=1 that cycle; next state DECODE.
- DECODE: one cycle; next state EXEC. No strobes.
- EXEC: latch the decode inputs and the computed byteenable. Priority of next state:
  - halt → HALT
  - misaligned load/store → HALT with fault=1
  - load → MEM
  - store → MEM
  - else → WRITEBACK
- Load and store both high: treat as load.
- Alignment rules:
  - half requires mem_addr_lo[0]=0.
  - word requires mem_addr_lo=00.
  - byte is always legal.
- MEM load: read=1 with latched byteenable; hold while waitrequest=1. On waitrequest=0, next state WRITEBACK.
  - The data register loads every MEM cycle, so the value held is from the accepting cycle.
- MEM store: write=1 with latched byteenable; hold while waitrequest=1. On waitrequest=0: pc_write=1, next state FETCH (no WRITEBACK).
- byteenable encoding:
  - byte: 0001 shifted left by mem_addr_lo.
  - half: 0011 if addr[1]=0, else 1100.
  - word: 1111.
  - 0000 in states other than FETCH and MEM.
- WRITEBACK: rf_write=latched writes_rf (always 1 for loads); pc_write=1; next state FETCH. One cycle.
- HALT: terminal until reset.
  - active=0 registered, taking effect the cycle after HALT is entered.
  - All strobes 0; fault holds.
- Strobes and pulses are decoded combinationally from state plus waitrequest.
- read and write are never high together.
- waitrequest is ignored outside FETCH and MEM.
- Latency, zero wait states:
  - ALU instruction: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each waitrequest cycle adds one.

Optional Feature:
- Macro: MEM_STALL_COUNT_EN.
- With the macro defined:
  - Extra output stall_cycles (32) counts cycles with (read|write)&waitrequest.
  - Cleared on reset; saturates at 32'hFFFFFFFF; frozen in HALT.
- Without the macro: port and counter absent; all other behaviour identical.

Test Plan:
- Reset for 2 cycles, release, waitrequest=0, ALU op with writes_rf=1 → state 0,1,2,4,0; ir_load in cycle 0; rf_write and pc_write in cycle 4; read high only in FETCH.
- Load word, addr_lo=00, waitrequest high 3 cycles in MEM → state holds 3 for 4 cycles with read=1 and byteenable=1111; then WRITEBACK with rf_write=1.
- Store byte to addr_lo=10, waitrequest=0 → MEM with write=1 and byteenable=0100; next state FETCH with pc_write=1; rf_write never asserted.
- Load half at addr_lo=01 → HALT from EXEC, fault=1, active=0 next cycle; no read issued; stays halted until reset, then fault=0.
- Halt and load both set in EXEC → HALT, no MEM state. Reset asserted mid-MEM with waitrequest=1 → read=0 that cycle; state=0 next cycle.
- MEM_STALL_COUNT_EN: 2 FETCH stalls plus 3 MEM stalls → stall_cycles=5; unchanged after HALT.
